// File: rtl/matrix_mac_if.sv
// matrix_mac_if: valid/ready handshake bundle for matrix_mac_unit.
//   master: in_valid, mode, a, b, out_ready -> ; <- in_ready, out_valid, result
//   slave : mirror of master
interface matrix_mac_if #(
    parameter int WIDTH_V = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [WIDTH_V-1:0] a;
    logic [WIDTH_V-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_V-1:0] result;
    modport master(output in_valid, mode, a, b, out_ready, input in_ready, out_valid, result);
    modport slave(input in_valid, mode, a, b, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/matrix_mac_unit.sv
// matrix_mac_unit: multi-cycle DIM x DIM unsigned matmul (one row per clock) or one-clock elementwise mul/add.
//   clk, rst : clock, synchronous active-high reset
//   bus      : matrix_mac_if.slave (in_valid/in_ready, mode, a, b, out_valid/out_ready, result)
//   SATURATE_EN defined: clamp results to all ones; otherwise keep low BITS_INDEX bits.
module matrix_mac_unit #(
    parameter int DIM        = 4,
    parameter int BITS_INDEX = 8,
    parameter int WIDTH_V    = DIM * DIM * BITS_INDEX
) (
    input logic         clk,
    input logic         rst,
    matrix_mac_if.slave bus
);
    localparam int N     = DIM * DIM;
    localparam int ACC_W = 2 * BITS_INDEX + $clog2(DIM);
    localparam int ROW_W = $clog2(DIM);
    localparam int RW    = BITS_INDEX * DIM;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [WIDTH_V-1:0]   a_q;
    logic [WIDTH_V-1:0]   b_q;
    logic [WIDTH_V-1:0]   res_q;
    logic [1:0]           mode_q;
    logic [ROW_W-1:0]     row;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [RW-1:0]        row_val;
    logic [WIDTH_V-1:0]   elem_val;

    // Element 0 sits at the MSBs.
    function automatic logic [BITS_INDEX-1:0] el(input logic [WIDTH_V-1:0] v, input int idx);
        return v[BITS_INDEX*(N-idx)-1 -: BITS_INDEX];
    endfunction

    function automatic logic [BITS_INDEX-1:0] reduce(input logic [ACC_W-1:0] v);
`ifdef SATURATE_EN
        return ((v >> BITS_INDEX) != '0) ? '1 : BITS_INDEX'(v);
`else
        return BITS_INDEX'(v);
`endif
    endfunction

    function automatic logic [ACC_W-1:0] dot(input logic [WIDTH_V-1:0] x, input logic [WIDTH_V-1:0] y,
                                             input int r, input int j);
        logic [ACC_W-1:0] s;
        s = '0;
        for (int k = 0; k < DIM; k++)
            s += ACC_W'(el(x, r*DIM+k)) * ACC_W'(el(y, k*DIM+j));
        return s;
    endfunction

    always_comb begin
        row_val = '0;
        for (int j = 0; j < DIM; j++)
            row_val[BITS_INDEX*(DIM-j)-1 -: BITS_INDEX] = reduce(dot(a_q, b_q, int'(row), j));
    end

    always_comb begin
        elem_val = '0;
        for (int i = 0; i < N; i++)
            elem_val[BITS_INDEX*(N-i)-1 -: BITS_INDEX] = reduce(mode_q == 2'b01
                ? ACC_W'(el(a_q, i)) * ACC_W'(el(b_q, i))
                : ACC_W'(el(a_q, i)) + ACC_W'(el(b_q, i)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    mode_q     <= bus.mode;
                    res_q      <= '0;
                    row        <= '0;
                    in_ready_q <= 1'b0;
                    state      <= BUSY;
                end
                BUSY: if (mode_q == 2'b00) begin
                    res_q[RW*(DIM-int'(row))-1 -: RW] <= row_val;
                    row <= row + 1'b1;
                    if (row == ROW_W'(DIM-1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end else begin
                    // Reserved mode leaves the cleared result untouched.
                    if (mode_q != 2'b11)
                        res_q <= elem_val;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
endmodule

// File: tb/tb_matrix_mac_unit.sv
// tb_matrix_mac_unit: randomized checks of matrix_mac_unit (4x4x8 and 3x3x16) against an arithmetic reference model.
module tb_matrix_mac_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    matrix_mac_if #(.WIDTH_V(128)) bus4();
    matrix_mac_if #(.WIDTH_V(144)) bus3();

    matrix_mac_unit #(.DIM(4), .BITS_INDEX(8),  .WIDTH_V(128)) u_dut4(.clk(clk), .rst(rst), .bus(bus4));
    matrix_mac_unit #(.DIM(3), .BITS_INDEX(16), .WIDTH_V(144)) u_dut3(.clk(clk), .rst(rst), .bus(bus3));

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] rnd();
        return {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Element i of an n-element row-major matrix lives at bits bw*(n-i)-1 downto bw*(n-1-i).
    function automatic logic [143:0] model(input int dim, input int bw, input logic [143:0] a,
                                           input logic [143:0] b, input logic [1:0] m);
        longint ea[16];
        longint eb[16];
        longint v;
        longint lim;
        logic [143:0] r;
        int n;
        n = dim * dim;
        r = '0;
        lim = (longint'(1) << bw) - 1;
        for (int i = 0; i < n; i++) begin
            ea[i] = 0;
            eb[i] = 0;
            for (int t = 0; t < bw; t++) begin
                ea[i][t] = a[bw*(n-1-i)+t];
                eb[i][t] = b[bw*(n-1-i)+t];
            end
        end
        for (int i = 0; i < n; i++) begin
            v = 0;
            if (m == 2'd0)
                for (int k = 0; k < dim; k++) v += ea[(i/dim)*dim+k] * eb[k*dim+i%dim];
            else if (m == 2'd1)
                v = ea[i] * eb[i];
            else if (m == 2'd2)
                v = ea[i] + eb[i];
`ifdef SATURATE_EN
            if (v > lim) v = lim;
`else
            v = v & lim;
`endif
            for (int t = 0; t < bw; t++) r[bw*(n-1-i)+t] = v[t];
        end
        return r;
    endfunction

    task automatic op4(input string tag, input logic [127:0] a, input logic [127:0] b, input logic [1:0] m);
        logic [143:0] exp;
        int lat;
        bit busy_rdy;
        exp = model(4, 8, {16'h0, a}, {16'h0, b}, m);
        check({tag, "_rdy"}, 144'(bus4.in_ready), 144'(1));
        bus4.a = a;
        bus4.b = b;
        bus4.mode = m;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.a = rnd()[127:0];
        bus4.b = rnd()[127:0];
        bus4.mode = 2'($urandom);
        lat = 0;
        busy_rdy = 1'b0;
        while (!bus4.out_valid && lat < 40) begin
            busy_rdy |= bus4.in_ready;
            @(posedge clk); #1;
            lat++;
        end
        busy_rdy |= bus4.in_ready;
        check({tag, "_lat"}, 144'(lat), 144'(m == 2'd0 ? 4 : 1));
        check({tag, "_busyrdy"}, 144'(busy_rdy), 144'(0));
        check({tag, "_res"}, 144'(bus4.result), exp);
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check({tag, "_ovlow"}, 144'(bus4.out_valid), 144'(0));
        check({tag, "_kept"}, 144'(bus4.result), exp);
    endtask

    task automatic op3(input string tag, input logic [143:0] a, input logic [143:0] b, input logic [1:0] m);
        logic [143:0] exp;
        int lat;
        exp = model(3, 16, a, b, m);
        check({tag, "_rdy"}, 144'(bus3.in_ready), 144'(1));
        bus3.a = a;
        bus3.b = b;
        bus3.mode = m;
        bus3.in_valid = 1'b1;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        bus3.a = rnd();
        bus3.b = rnd();
        lat = 0;
        while (!bus3.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 144'(lat), 144'(m == 2'd0 ? 3 : 1));
        check({tag, "_res"}, bus3.result, exp);
        bus3.out_ready = 1'b1;
        @(posedge clk); #1;
        bus3.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] ia;
        logic [127:0] ib;
        logic [127:0] snap;
        int n;
        bit stable;
        bus4.in_valid = 0; bus4.out_ready = 0; bus4.mode = 0; bus4.a = '0; bus4.b = '0;
        bus3.in_valid = 0; bus3.out_ready = 0; bus3.mode = 0; bus3.a = '0; bus3.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res", 144'(bus4.result), 144'(0));
        check("rst_ov", 144'(bus4.out_valid), 144'(0));
        check("rst_rdy", 144'(bus4.in_ready), 144'(1));
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            ia[8*(16-i)-1 -: 8] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
            ib[8*(16-i)-1 -: 8] = 8'(i + 1);
        end
        op4("ident", ia, ib, 2'd0);
        check("ident_eqb", 144'(bus4.result), 144'(ib));

        op4("all10", {16{8'h10}}, {16{8'h10}}, 2'd0);
        op4("emul", {16{8'h0f}}, {16{8'h11}}, 2'd1);
        check("emul_ff", 144'(bus4.result), 144'({16{8'hff}}));
        op4("eadd", {16{8'hf0}}, {16{8'h20}}, 2'd2);
        op4("resv", rnd()[127:0], rnd()[127:0], 2'd3);
        for (int i = 0; i < 20; i++)
            op4($sformatf("r4_%0d", i), rnd()[127:0], rnd()[127:0], 2'($urandom_range(0, 3)));

        // Backpressure: hold out_ready low in DONE while poking in_valid.
        ia = rnd()[127:0];
        ib = rnd()[127:0];
        bus4.a = ia; bus4.b = ib; bus4.mode = 2'd0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", 144'(n), 144'(4));
        snap = bus4.result;
        check("bp_res", 144'(snap), model(4, 8, {16'h0, ia}, {16'h0, ib}, 2'd0));
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus4.in_valid = c[0];
            bus4.a = rnd()[127:0];
            bus4.mode = 2'd1;
            @(posedge clk); #1;
            stable &= (bus4.result == snap) && bus4.out_valid && !bus4.in_ready;
        end
        check("bp_stable", 144'(stable), 144'(1));
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("bp_rdy", 144'(bus4.in_ready), 144'(1));
        check("bp_ov", 144'(bus4.out_valid), 144'(0));
        check("bp_kept", 144'(bus4.result), 144'(snap));
        op4("bp_next", rnd()[127:0], rnd()[127:0], 2'd2);

        // Reset while the row counter is at 2.
        bus4.a = rnd()[127:0]; bus4.b = rnd()[127:0]; bus4.mode = 2'd0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_res", 144'(bus4.result), 144'(0));
        check("abort_ov", 144'(bus4.out_valid), 144'(0));
        check("abort_rdy", 144'(bus4.in_ready), 144'(1));
        op4("after_abort", rnd()[127:0], rnd()[127:0], 2'd0);

        op3("d3_resv", rnd(), rnd(), 2'd3);
        op3("d3_mm", rnd(), rnd(), 2'd0);
        for (int i = 0; i < 12; i++)
            op3($sformatf("r3_%0d", i), rnd(), rnd(), 2'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
